accumulator_sequencer: RTL and testbench
========================================

// Module: accumulator_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute controller for the 8-bit accumulator CPU.
//  Owns PC, AR, IR, AC and E. Sequences the shared 32x8 synchronous memory and the external carry-select adder.
//  Runs the instruction set: bit7 = I (indirect); bits6:5 = opcode: 00 ADD, 01 DBL, 10 LDA, 11 HLT; bits4:0 = address.
//  Sits between the top-level run control (start/halt) and the memory/adder datapath.
// PARAMETERS
//  ADDR_W  5  memory address width (PC, AR width; 32 words)
//  DATA_W  8  memory word, IR, AC and adder operand width
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       one-cycle run request; sampled only in IDLE or HALT
//  start_pc   in   ADDR_W  PC loaded on accepted start
//  mem_addr   out  ADDR_W  memory address (read data valid next cycle)
//  mem_we     out  1       memory write strobe, one cycle
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, 1-cycle latency after mem_addr
//  add_a      out  DATA_W  adder operand A (AC)
//  add_b      out  DATA_W  adder operand B (operand word)
//  add_cin    out  1       adder carry-in, always 0
//  add_sum    in   DATA_W  adder sum, combinational from add_a/add_b/add_cin
//  add_cout   in   1       adder carry-out
//  ac         out  DATA_W  accumulator
//  e          out  1       carry/extend flag
//  pc         out  ADDR_W  program counter
//  busy       out  1       high in every state except IDLE and HALT
//  halted     out  1       high in HALT
//  instr_done out  1       one-cycle pulse on the last cycle of each instruction
// BEHAVIOUR
//  Reset (async): state=IDLE; pc, ar, ir, ac, e = 0; mem_we=0; instr_done=0; busy=0; halted=0.
//  Memory and adder outputs are combinational from state/regs; mem_addr=pc in IDLE/HALT, mem_wdata=0 except in EXEC.
//  States and transitions:
//   IDLE:   start=1 -> pc<=start_pc; go to FETCH.
//   FETCH:  mem_addr=pc -> DECODE.
//   DECODE: ir<=mem_rdata; ar<=mem_rdata[4:0]; pc<=pc+1 (wraps 31->0).
//           op=11 -> HALT with instr_done=1, I bit ignored. I=1 -> INDIR. Else -> OPRD.
//   INDIR:  mem_addr=ar -> INDIR_W.
//   INDIR_W: ar<=mem_rdata[4:0]; upper 3 bits discarded -> OPRD.
//   OPRD:   mem_addr=ar -> EXEC.
//   EXEC:   instr_done=1 -> FETCH.
//           ADD: add_a=ac, add_b=mem_rdata; ac<=add_sum; e<=add_cout.
//           LDA: ac<=mem_rdata; e unchanged.
//           DBL: mem_addr=ar, mem_we=1, mem_wdata={mem_rdata[6:0],1'b0}; e<=mem_rdata[7]; ac unchanged.
//   HALT:   start=1 -> pc<=start_pc; go to FETCH. Regs hold otherwise.
//  Latency in cycles from the FETCH cycle through the instr_done cycle:
//   direct ADD/LDA/DBL = 4; indirect = 6; HLT = 2.
//  start while busy: ignored, no effect.
//  Arithmetic is modulo 2^DATA_W; overflow goes only to e.
//  DBL to the address holding the current instruction is legal; the new value is seen on the next fetch.
//  Indirect pointer equal to its own address: legal, single dereference only.
//  Reset mid-instruction: async clear; any in-flight write is dropped (mem_we falls immediately).
// TESTING
//  Program: mem[0]=0x45 (LDA 5), mem[1]=0x06 (ADD 6), mem[2]=0x60 (HLT), mem[5]=0x0C, mem[6]=0xFA;
//   start, start_pc=0 -> ac=0x06, e=1, pc=3, halted=1 on the 11th cycle after start; 3 instr_done pulses.
//  Indirect: mem[0]=0x83, mem[3]=0x10, mem[16]=0x22, mem[1]=0x60, ac=0 -> ac=0x22, e=0; first instr_done 6 cycles after FETCH.
//  DBL: mem[0]=0x29, mem[9]=0x81 -> single write addr 9 data 0x02, e=1, ac unchanged.
//  Wrap: start_pc=31, mem[31]=0x45, mem[0]=0x60 -> second fetch at addr 0; halted with pc=1.
//  Start while busy: pulse start with start_pc=7 during DECODE -> ignored; program result identical to the first test.
//  Reset during the EXEC of a DBL -> mem_we=0 the same cycle; all outputs return to reset values; no memory change.

Source files
------------

// File: rtl/accumulator_sequencer.sv
// rtl/accumulator_sequencer.sv - fetch/decode/execute controller for the 8-bit accumulator CPU
// Owns PC/AR/IR/AC/E and drives the shared synchronous memory and external adder.
module accumulator_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic [DATA_W-1:0] ac,
    output logic              e,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              instr_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_INDIR, S_INDIR_W, S_OPRD, S_EXEC, S_HALT
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_DBL = 2'b01;
    localparam logic [1:0] OP_LDA = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ar;
    logic [1:0]        r_ir_op;
    logic [DATA_W-1:0] r_ac;
    logic              r_e;

    logic [1:0]        w_dec_op;
    logic              w_dec_ind;
    logic              w_dbl_write;

    assign w_dec_op    = mem_rdata[DATA_W-2 -: 2];
    assign w_dec_ind   = mem_rdata[DATA_W-1];
    assign w_dbl_write = (r_state == S_EXEC) && (r_ir_op == OP_DBL);

    // Memory and adder controls decode straight from state so a reset drops them at once.
    always_comb begin
        mem_addr = r_pc;
        case (r_state)
            S_INDIR, S_OPRD, S_EXEC: mem_addr = r_ar;
            default:                 mem_addr = r_pc;
        endcase
    end

    assign mem_we     = w_dbl_write;
    assign mem_wdata  = w_dbl_write ? {mem_rdata[DATA_W-2:0], 1'b0} : '0;
    assign add_a      = r_ac;
    assign add_b      = mem_rdata;
    assign add_cin    = 1'b0;
    assign ac         = r_ac;
    assign e          = r_e;
    assign pc         = r_pc;
    assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted     = (r_state == S_HALT);
    assign instr_done = (r_state == S_EXEC) || ((r_state == S_DECODE) && (w_dec_op == OP_HLT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ar    <= '0;
            r_ir_op <= OP_ADD;
            r_ac    <= '0;
            r_e     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc    <= start_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    // Only the opcode field of IR is needed once decode has routed the instruction.
                    r_ir_op <= w_dec_op;
                    r_ar    <= mem_rdata[ADDR_W-1:0];
                    r_pc    <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (w_dec_op == OP_HLT)
                        r_state <= S_HALT;
                    else if (w_dec_ind)
                        r_state <= S_INDIR;
                    else
                        r_state <= S_OPRD;
                end
                S_INDIR: r_state <= S_INDIR_W;
                S_INDIR_W: begin
                    r_ar    <= mem_rdata[ADDR_W-1:0];
                    r_state <= S_OPRD;
                end
                S_OPRD: r_state <= S_EXEC;
                S_EXEC: begin
                    case (r_ir_op)
                        OP_ADD: begin
                            r_ac <= add_sum;
                            r_e  <= add_cout;
                        end
                        OP_LDA:  r_ac <= mem_rdata;
                        OP_DBL:  r_e  <= mem_rdata[DATA_W-1];
                        default: r_ac <= r_ac;
                    endcase
                    r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb/tb_accumulator_sequencer.sv - directed bench for accumulator_sequencer
// Models the 32x8 synchronous memory and the adder around the controller.
module tb_accumulator_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] start_pc;
    logic [4:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic [7:0] ac;
    logic       e;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
    logic       instr_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    accumulator_sequencer #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .ac(ac), .e(e), .pc(pc), .busy(busy), .halted(halted), .instr_done(instr_done)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    logic [7:0] mem [0:31];
    logic       ld_en;
    logic [4:0] ld_addr;
    logic [7:0] ld_data;
    logic       clr;
    int         done_count;
    int         wr_count;
    logic [4:0] last_wa;
    logic [7:0] last_wd;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (clr) begin
            done_count <= 0;
            wr_count   <= 0;
        end else begin
            if (instr_done) done_count <= done_count + 1;
            if (mem_we) begin
                wr_count <= wr_count + 1;
                last_wa  <= mem_addr;
                last_wd  <= mem_wdata;
            end
        end
    end

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) poke(i[4:0], 8'h00);
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge of the FETCH cycle (cycle 1 after the accepting edge).
    task automatic do_start(input logic [4:0] p);
        start = 1'b1; start_pc = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int c0, output int cyc);
        cyc = c0;
        while (!halted && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic load_basic_program();
        clear_mem();
        poke(5'd0, 8'h45); poke(5'd1, 8'h06); poke(5'd2, 8'h60);
        poke(5'd5, 8'h0C); poke(5'd6, 8'hFA); poke(5'd7, 8'h60);
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (pc !== 5'd0) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
        total++; if (ac !== 8'h00) begin bad++; $display("FAIL reset_ac: got %h want 00", ac); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL reset_e: got %b want 0", e); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
        total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", instr_done); end
    endtask

    task automatic test_program();
        int cyc;
        load_basic_program();
        clear_counts();
        do_start(5'd0);
        wait_halt(1, cyc);
        total++; if (cyc != 11) begin bad++; $display("FAIL prog_cycles: got %0d want 11", cyc); end
        total++; if (ac !== 8'h06) begin bad++; $display("FAIL prog_ac: got %h want 06", ac); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL prog_e: got %b want 1", e); end
        total++; if (pc !== 5'd3) begin bad++; $display("FAIL prog_pc: got %h want 03", pc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prog_busy: got %b want 0", busy); end
        total++; if (done_count != 3) begin bad++; $display("FAIL prog_done: got %0d want 3", done_count); end
    endtask

    task automatic test_indirect();
        int cyc;
        pulse_reset();
        clear_mem();
        poke(5'd0, 8'h83); poke(5'd3, 8'h10); poke(5'd16, 8'h22); poke(5'd1, 8'h60);
        clear_counts();
        do_start(5'd0);
        cyc = 1;
        while (!instr_done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc != 6) begin bad++; $display("FAIL ind_latency: got %0d want 6", cyc); end
        wait_halt(cyc, cyc);
        total++; if (ac !== 8'h22) begin bad++; $display("FAIL ind_ac: got %h want 22", ac); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ind_e: got %b want 0", e); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ind_halted: got %b want 1", halted); end
    endtask

    task automatic test_dbl();
        int cyc;
        clear_mem();
        poke(5'd0, 8'h29); poke(5'd9, 8'h81); poke(5'd1, 8'h60);
        clear_counts();
        do_start(5'd0);
        wait_halt(1, cyc);
        total++; if (wr_count != 1) begin bad++; $display("FAIL dbl_writes: got %0d want 1", wr_count); end
        total++; if (last_wa !== 5'd9) begin bad++; $display("FAIL dbl_waddr: got %h want 09", last_wa); end
        total++; if (last_wd !== 8'h02) begin bad++; $display("FAIL dbl_wdata: got %h want 02", last_wd); end
        total++; if (mem[9] !== 8'h02) begin bad++; $display("FAIL dbl_mem9: got %h want 02", mem[9]); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL dbl_e: got %b want 1", e); end
        total++; if (ac !== 8'h22) begin bad++; $display("FAIL dbl_ac: got %h want 22", ac); end
    endtask

    task automatic test_wrap();
        int cyc;
        clear_mem();
        poke(5'd31, 8'h45); poke(5'd0, 8'h60); poke(5'd5, 8'h3C);
        clear_counts();
        do_start(5'd31);
        wait_halt(1, cyc);
        total++; if (cyc != 7) begin bad++; $display("FAIL wrap_cycles: got %0d want 7", cyc); end
        total++; if (pc !== 5'd1) begin bad++; $display("FAIL wrap_pc: got %h want 01", pc); end
        total++; if (ac !== 8'h3C) begin bad++; $display("FAIL wrap_ac: got %h want 3c", ac); end
        total++; if (done_count != 2) begin bad++; $display("FAIL wrap_done: got %0d want 2", done_count); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        load_basic_program();
        clear_counts();
        do_start(5'd0);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_decode: got %b want 1", busy); end
        start = 1'b1; start_pc = 5'd7;
        @(negedge clk);
        start = 1'b0;
        wait_halt(3, cyc);
        total++; if (cyc != 11) begin bad++; $display("FAIL busy_cycles: got %0d want 11", cyc); end
        total++; if (ac !== 8'h06) begin bad++; $display("FAIL busy_ac: got %h want 06", ac); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL busy_e: got %b want 1", e); end
        total++; if (pc !== 5'd3) begin bad++; $display("FAIL busy_pc: got %h want 03", pc); end
        total++; if (done_count != 3) begin bad++; $display("FAIL busy_done: got %0d want 3", done_count); end
    endtask

    task automatic test_reset_mid_dbl();
        clear_mem();
        poke(5'd0, 8'h29); poke(5'd9, 8'h81); poke(5'd1, 8'h60);
        clear_counts();
        do_start(5'd0);
        repeat (3) @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmid_we_exec: got %b want 1", mem_we); end
        total++; if (mem_addr !== 5'd9) begin bad++; $display("FAIL rmid_addr_exec: got %h want 09", mem_addr); end
        rst = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_we: got %b want 0", mem_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (pc !== 5'd0) begin bad++; $display("FAIL rmid_pc: got %h want 00", pc); end
        total++; if (ac !== 8'h00) begin bad++; $display("FAIL rmid_ac: got %h want 00", ac); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL rmid_e: got %b want 0", e); end
        total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", instr_done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (mem[9] !== 8'h81) begin bad++; $display("FAIL rmid_mem9: got %h want 81", mem[9]); end
        total++; if (wr_count != 0) begin bad++; $display("FAIL rmid_writes: got %0d want 0", wr_count); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rmid_halted: got %b want 0", halted); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_pc = 5'd0;
        ld_en = 1'b0; ld_addr = 5'd0; ld_data = 8'h00; clr = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        test_program();
        test_indirect();
        test_dbl();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_dbl();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
